// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between NUM_REQUESTERS producers, the arbiter and the
// asynchronous FIFO write side. The master modport is the arbiter's view;
// the slave modport is the producers/FIFO view.
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQUESTERS = 4
);
  localparam int INDEX_WIDTH = ($clog2(NUM_REQUESTERS) > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [NUM_REQUESTERS-1:0]            Request;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] Request_Data;
  logic [NUM_REQUESTERS-1:0]            Accept;
  logic                                 Full;
  logic                                 Write_Enable;
  logic [DATA_WIDTH-1:0]                Data_In;
  logic                                 Grant_Valid;
  logic [INDEX_WIDTH-1:0]               Grant_Index;

  modport master (
    input  Request, Request_Data, Full,
    output Accept, Write_Enable, Data_In, Grant_Valid, Grant_Index
  );

  modport slave (
    output Request, Request_Data, Full,
    input  Accept, Write_Enable, Data_In, Grant_Valid, Grant_Index
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for the asynchronous FIFO. A granted
// requester may write up to MAX_BURST words before the grant rotates; one
// IDLE arbitration cycle separates bursts.
// Optional macro FIFO_WRITE_ARB_PRIORITY_EN: requester 0 wins every
// arbitration it takes part in; otherwise pure round-robin.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQUESTERS = 4,
  parameter int MAX_BURST      = 4
) (
  input  logic                  Write_Clock,
  input  logic                  Write_Reset_Enable,
  fifo_write_arbiter_if.master  wr
);

  localparam int INDEX_WIDTH = ($clog2(NUM_REQUESTERS) > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int COUNT_WIDTH = ($clog2(MAX_BURST) > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_REQUESTERS - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                   state, next_state;
  logic [INDEX_WIDTH-1:0]   grant_index, next_grant_index;
  logic [INDEX_WIDTH-1:0]   rr_ptr, next_rr_ptr;
  logic [COUNT_WIDTH-1:0]   burst_count, next_burst_count;

  logic [INDEX_WIDTH-1:0]   winner;
  logic                     winner_found;
  logic [INDEX_WIDTH-1:0]   wrapped_index;
  logic                     granted_request;
  logic [DATA_WIDTH-1:0]    granted_data;
  logic                     transfer;
  logic [2*NUM_REQUESTERS-1:0] rotated_request;
  int unsigned              winner_sum;

  // Select the granted requester's valid bit and data word
  always_comb begin
    granted_request = 1'b0;
    granted_data    = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_index == INDEX_WIDTH'(i)) begin
        granted_request = wr.Request[i];
        granted_data    = wr.Request_Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wrapped_index = (grant_index == LAST_INDEX) ? '0 : grant_index + 1'b1;
  assign transfer      = (state == BURST) && granted_request && !wr.Full;

  // Find the arbitration winner searching upward from the RR pointer
  always_comb begin
    // Rotating a doubled copy puts the pointer's requester at bit 0, so the
    // lowest set bit is the wrap-around search result offset.
    rotated_request = {wr.Request, wr.Request} >> rr_ptr;
    winner          = '0;
    winner_found    = 1'b0;
    winner_sum      = 0;
`ifdef FIFO_WRITE_ARB_PRIORITY_EN
    if (wr.Request[0]) begin
      winner       = '0;
      winner_found = 1'b1;
    end
`endif
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (!winner_found && rotated_request[i]) begin
        winner_sum = 32'(rr_ptr) + i;
        if (winner_sum >= NUM_REQUESTERS) winner_sum = winner_sum - NUM_REQUESTERS;
        winner       = INDEX_WIDTH'(winner_sum);
        winner_found = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge Write_Clock or negedge Write_Reset_Enable) begin
    if (!Write_Reset_Enable) begin
      state       <= IDLE;
      grant_index <= '0;
      rr_ptr      <= '0;
      burst_count <= '0;
    end else begin
      state       <= next_state;
      grant_index <= next_grant_index;
      rr_ptr      <= next_rr_ptr;
      burst_count <= next_burst_count;
    end
  end

  // Next-state: grant on request, count transfers, end burst on cap or drop
  always_comb begin
    next_state       = state;
    next_grant_index = grant_index;
    next_rr_ptr      = rr_ptr;
    next_burst_count = burst_count;
    case (state)
      IDLE: begin
        if (winner_found) begin
          next_state       = BURST;
          next_grant_index = winner;
          next_burst_count = '0;
        end
      end
      BURST: begin
        if (!granted_request) begin
          next_state  = IDLE;
          next_rr_ptr = wrapped_index;
        end else if (transfer) begin
          if (burst_count == LAST_COUNT) begin
            next_state  = IDLE;
            next_rr_ptr = wrapped_index;
          end else begin
            next_burst_count = burst_count + 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs: handshake and FIFO strobe only while a burst is held
  always_comb begin
    wr.Accept       = '0;
    wr.Write_Enable = 1'b0;
    wr.Data_In      = '0;
    wr.Grant_Valid  = (state == BURST);
    wr.Grant_Index  = grant_index;
    if (state == BURST) begin
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
        wr.Accept[i] = (grant_index == INDEX_WIDTH'(i)) && !wr.Full;
      end
      wr.Write_Enable = transfer;
      wr.Data_In      = granted_data;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_fifo_write_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQUESTERS(N)) wr();

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQUESTERS(N), .MAX_BURST(MB)) dut (
    .Write_Clock        (clk),
    .Write_Reset_Enable (rst_n),
    .wr                 (wr)
  );

  int checks = 0;
  int errors = 0;

  // Producer stimulus: each requester presents the front of its word queue
  logic [DW-1:0] src_q [N][$];
  logic [N-1:0]  mask;
  logic          full_in;

  // Reference model: who owns the port, words written so far, next start
  bit m_busy;
  int m_owner;
  int m_words;
  int m_ptr;

  // Observed grant and write logs for scenario-level checks
  int            glog[$];
  int            exp_g[$];
  logic [DW-1:0] wlog[$];
  logic [DW-1:0] exp_w[$];
  bit            prev_gv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit req_of(input int i);
    return mask[i] && (src_q[i].size() > 0);
  endfunction

  function automatic int pick_winner();
`ifdef FIFO_WRITE_ARB_PRIORITY_EN
    if (req_of(0)) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (req_of((m_ptr + k) % N)) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      wr.Request[i] = req_of(i);
      wr.Request_Data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    wr.Full = full_in;
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance model
  task automatic step();
    bit            exp_we;
    logic [N-1:0]  exp_acc;
    int            w;
    drive();
    #1;
    exp_we  = m_busy && req_of(m_owner) && !full_in;
    exp_acc = (m_busy && !full_in) ? N'(1 << m_owner) : '0;
    chk("grant_valid", 64'(wr.Grant_Valid), 64'(m_busy));
    chk("grant_index", 64'(wr.Grant_Index), 64'(m_owner));
    chk("write_enable", 64'(wr.Write_Enable), 64'(exp_we));
    chk("accept", 64'(wr.Accept), 64'(exp_acc));
    if (exp_we) chk("data_in", 64'(wr.Data_In), 64'(src_q[m_owner][0]));
    if (wr.Grant_Valid === 1'b1 && !prev_gv) glog.push_back(int'(wr.Grant_Index));
    prev_gv = (wr.Grant_Valid === 1'b1);
    if (wr.Write_Enable === 1'b1) wlog.push_back(wr.Data_In);
    if (!m_busy) begin
      w = pick_winner();
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_words = 0;
      end
    end else if (!req_of(m_owner)) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end else if (!full_in) begin
      void'(src_q[m_owner].pop_front());
      m_words++;
      if (m_words == MB) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  // Assert reset at a negedge, check the immediate abort, release later
  task automatic reset_for(input int cycles);
    rst_n = 1'b0;
    #1;
    chk("rst_grant_valid", 64'(wr.Grant_Valid), 64'd0);
    chk("rst_write_enable", 64'(wr.Write_Enable), 64'd0);
    chk("rst_accept", 64'(wr.Accept), 64'd0);
    chk("rst_grant_index", 64'(wr.Grant_Index), 64'd0);
    m_busy  = 1'b0;
    m_owner = 0;
    m_words = 0;
    m_ptr   = 0;
    prev_gv = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic chk_glog(input string tag);
    chk({tag, "_count"}, 64'(glog.size()), 64'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < glog.size(); i++)
      chk(tag, 64'(glog[i]), 64'(exp_g[i]));
  endtask

  task automatic chk_wlog(input string tag);
    chk({tag, "_count"}, 64'(wlog.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
      chk(tag, 64'(wlog[i]), 64'(exp_w[i]));
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    glog.delete();
    wlog.delete();
  endtask

  initial begin
    int base;
    rst_n   = 1'b0;
    mask    = '0;
    full_in = 1'b0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_words = 0;
    m_ptr   = 0;
    prev_gv = 1'b0;
    drive();
    @(negedge clk);

    // Reset release with no requests: nothing happens for 10 cycles
    reset_for(3);
    repeat (10) step();

    // Single requester 2, two back-to-back bursts of 4
    clear_all();
    for (int j = 0; j < 8; j++) src_q[2].push_back(8'(8'h10 + j));
    mask = 4'b0100;
    repeat (12) step();
    exp_g = '{2, 2};
    chk_glog("p2_grants");
    exp_w = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    chk_wlog("p2_writes");

    // All requesters busy: rotation with one gap cycle between bursts
    reset_for(2);
    clear_all();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 16; j++) src_q[i].push_back(8'(i * 16 + j));
    mask = 4'b1111;
    repeat (25) step();
`ifdef FIFO_WRITE_ARB_PRIORITY_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    chk_glog("p3_grants");
    chk("p3_write_count", 64'(wlog.size()), 64'd20);
    mask = '0;
    wait_idle();

    // Full stall mid-burst: grant held, no writes, then burst completes
    reset_for(2);
    clear_all();
    for (int j = 0; j < 4; j++) src_q[1].push_back(8'(8'hA0 + j));
    mask = 4'b0010;
    repeat (3) step();
    full_in = 1'b1;
    repeat (5) step();
    chk("p4_stall_writes", 64'(wlog.size()), 64'd2);
    full_in = 1'b0;
    repeat (3) step();
    exp_w = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk_wlog("p4_writes");
    chk("p4_ptr_idle", 64'(wr.Grant_Valid), 64'd0);

    // Requester 3 drops after one word; pointer wraps so 0 wins next
    clear_all();
    src_q[3].push_back(8'h33);
    for (int j = 0; j < 4; j++) src_q[0].push_back(8'(8'hC0 + j));
    mask = 4'b1000;
    step();
    mask = 4'b1001;
    repeat (8) step();
    exp_g = '{3, 0};
    chk_glog("p5_grants");
    exp_w = '{8'h33, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    chk_wlog("p5_writes");

    // Reset mid-burst after two writes, then fresh grant from pointer 0
    clear_all();
    for (int j = 0; j < 4; j++) src_q[2].push_back(8'(8'hE0 + j));
    mask = 4'b0100;
    repeat (3) step();
    reset_for(2);
    clear_all();
    src_q[1].push_back(8'h5A);
    src_q[1].push_back(8'h5B);
    mask = 4'b0010;
    repeat (2) step();
    exp_g = '{1};
    chk_glog("p6_grants");
    wait_idle();

    // Randomized traffic with random Full and occasional request changes
    clear_all();
    mask = 4'b1111;
    base = 0;
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      full_in = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 2) begin
          src_q[i].push_back(8'(base));
          base++;
        end
      step();
    end
    full_in = 1'b0;
    mask    = '0;
    wait_idle();

`ifdef FIFO_WRITE_ARB_PRIORITY_EN
    // Requester 0 keeps winning while asserted; then rotation resumes at 1
    reset_for(2);
    clear_all();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 40; j++) src_q[i].push_back(8'(j));
    mask = 4'b1011;
    repeat (15) step();
    exp_g = '{0, 0, 0};
    chk_glog("p8_priority");
    glog.delete();
    mask = 4'b1010;
    wait_idle();
    repeat (2) step();
    exp_g = '{1};
    chk_glog("p8_after");
    mask = '0;
    wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
